// File: rtl/coin_acceptor_pkg.sv
// Shared vending definitions: coin codes handed to the vending machine and the
// sensor debounce state encoding.
package coin_acceptor_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10
    } coin_code_t;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_ARMING,
        DB_HELD,
        DB_RELEASING
    } db_state_t;

    // Debounce run counter width; covers DEBOUNCE_CYCLES up to 15.
    localparam int DB_CNT_W = 4;

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin acceptor to vending machine link: coin code strobe, reject pulse,
// buffer occupancy and the machine's ready signal.
interface coin_acceptor_if
    import coin_acceptor_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);

    logic                         accept_en;
    coin_code_t                   in_code;
    logic                         coin_reject;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    modport master (
        input  accept_en,
        output in_code,
        output coin_reject,
        output fifo_count
    );

    modport slave (
        output accept_en,
        input  in_code,
        input  coin_reject,
        input  fifo_count
    );

endinterface

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchronizer followed by a 4-state debounce FSM that
// pulses detect_o once when a high level has been stable long enough.
module coin_debounce
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic detect_o
);

    localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync2_q;
    db_state_t           state_q, state_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sample that leaves IDLE/HELD is not counted; DEBOUNCE_CYCLES more must follow.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        detect_o = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (sync2_q) begin
                    state_d = DB_ARMING;
                    cnt_d   = '0;
                end
            end
            DB_ARMING: begin
                if (!sync2_q) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d  = DB_HELD;
                    cnt_d    = '0;
                    detect_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_HELD: begin
                if (!sync2_q) begin
                    state_d = DB_RELEASING;
                    cnt_d   = '0;
                end
            end
            DB_RELEASING: begin
                if (sync2_q) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: debounces both sensors, buffers validated coins in a small
// FIFO and hands them to the vending machine one strobe at a time.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin5_raw,
    input  logic             coin10_raw,
    coin_acceptor_if.master  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic det5, det10;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db5 (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (coin5_raw),
        .detect_o (det5)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db10 (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (coin10_raw),
        .detect_o (det10)
    );

    coin_code_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    coin_code_t             in_code_q, in_code_d;
    logic                   reject_q, reject_d;

    logic                   jam, single, full, pop, push;
    coin_code_t             push_code;

    always_comb begin
        jam       = det5 & det10;
        single    = det5 ^ det10;
        push_code = det5 ? COIN_5 : COIN_10;
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        // in_code_q doubles as "previous cycle's code", forcing an idle cycle between coins.
        pop       = bus.accept_en && (count_q != '0) && (in_code_q == COIN_NONE);
        push      = single && (!full || pop);
        reject_d  = jam || (single && full && !pop);
        in_code_d = pop ? fifo_mem[rd_ptr_q] : COIN_NONE;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            in_code_q <= COIN_NONE;
            reject_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            in_code_q <= in_code_d;
            reject_q  <= reject_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_code;
        end
    end

    assign bus.in_code     = in_code_q;
    assign bus.coin_reject = reject_q;
    assign bus.fifo_count  = count_q;

endmodule
